// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel-tick divider, h/v counters, a two-tick
// colour pipeline with blanking, and sync outputs delayed to line up with the colour register.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0,
  parameter int OUT_SYNC_DLY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pix_r,
  input  logic [3:0] pix_g,
  input  logic [3:0] pix_b,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_req,
  output logic       frame_start,
  output logic [3:0] rgb_r,
  output logic [3:0] rgb_g,
  output logic [3:0] rgb_b,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic          tick;
  logic [9:0]    h;
  logic [9:0]    v;
  logic          act0, hs0, vs0;
  logic          act1, hs1, vs1;
  logic          hs2, vs2;
  logic          hs_d, vs_d;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign pix_x = h;
  assign pix_y = v;

  assign act0 = (h < H_ACT) && (v < V_ACT);
  assign hs0  = (h >= HS_BEG) && (h < HS_END);
  assign vs0  = (v >= VS_BEG) && (v < VS_END);

  // pix_req is a one-clk strobe with no ready: the source captures (pix_x, pix_y)
  // on that edge and holds its colour valid for the whole following tick interval.
  // Gated by reset so it stays low in reset even when every clk is a tick.
  assign pix_req     = reset & tick & act0;
  assign frame_start = reset & tick & (h == H_LAST) & (v == V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act1  <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
      rgb_r <= 4'h0;
      rgb_g <= 4'h0;
      rgb_b <= 4'h0;
    end else if (tick) begin
      act1  <= act0;
      hs1   <= hs0;
      vs1   <= vs0;
      hs2   <= hs1;
      vs2   <= vs1;
      rgb_r <= act1 ? pix_r : 4'h0;
      rgb_g <= act1 ? pix_g : 4'h0;
      rgb_b <= act1 ? pix_b : 4'h0;
    end
  end

  generate
    if (OUT_SYNC_DLY == 0) begin : g_no_dly
      assign hs_d = hs2;
      assign vs_d = vs2;
    end else begin : g_dly
      logic [OUT_SYNC_DLY-1:0] hs_sr;
      logic [OUT_SYNC_DLY-1:0] vs_sr;

      // Per-clk shift, not per-tick: it matches the downstream colour register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hs_sr <= '0;
          vs_sr <= '0;
        end else begin
          hs_sr[0] <= hs2;
          vs_sr[0] <= vs2;
          for (int i = 1; i < OUT_SYNC_DLY; i++) begin
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
          end
        end
      end

      assign hs_d = hs_sr[OUT_SYNC_DLY-1];
      assign vs_d = vs_sr[OUT_SYNC_DLY-1];
    end
  endgenerate

  assign hsync = ~(hs_d ^ SYNC_POL);
  assign vsync = ~(vs_d ^ SYNC_POL);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instances at CLK_DIV=4 and 1 for line timing and
// pixel pipeline, plus a shrunken-timing instance for frame, blanking and mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_a, reset_b, reset_c;
  always #5 clk = ~clk;

  int cyc = 0;
  int rel_ab = 0;
  int rel_c = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Instance A: default 640x480 timing, CLK_DIV=4, pattern source.
  logic [3:0] a_pr = 4'h0, a_pg = 4'h0, a_pb = 4'h0;
  logic [3:0] a_r, a_g, a_b;
  logic [9:0] a_x, a_y;
  logic       a_req, a_fs, a_hs, a_vs;

  vga_timing_gen #(.CLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset_a), .pix_r(a_pr), .pix_g(a_pg), .pix_b(a_pb),
    .pix_x(a_x), .pix_y(a_y), .pix_req(a_req), .frame_start(a_fs),
    .rgb_r(a_r), .rgb_g(a_g), .rgb_b(a_b), .hsync(a_hs), .vsync(a_vs)
  );

  always @(posedge clk) begin
    if (a_req) begin
      a_pr <= a_x[3:0];
      a_pg <= a_y[3:0];
      a_pb <= a_x[7:4];
    end
  end

  // Instance B: default timing, CLK_DIV=1.
  logic [3:0] b_r, b_g, b_b;
  logic [9:0] b_x, b_y;
  logic       b_req, b_fs, b_hs, b_vs;

  vga_timing_gen #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset_b), .pix_r(4'h0), .pix_g(4'h0), .pix_b(4'h0),
    .pix_x(b_x), .pix_y(b_y), .pix_req(b_req), .frame_start(b_fs),
    .rgb_r(b_r), .rgb_g(b_g), .rgb_b(b_b), .hsync(b_hs), .vsync(b_vs)
  );

  // Instance C: 24x19 total (16x12 active), CLK_DIV=2, constant 0xF source.
  logic [3:0] c_r, c_g, c_b;
  logic [9:0] c_x, c_y;
  logic       c_req, c_fs, c_hs, c_vs;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_c (
    .clk(clk), .reset(reset_c), .pix_r(4'hF), .pix_g(4'hF), .pix_b(4'hF),
    .pix_x(c_x), .pix_y(c_y), .pix_req(c_req), .frame_start(c_fs),
    .rgb_r(c_r), .rgb_g(c_g), .rgb_b(c_b), .hsync(c_hs), .vsync(c_vs)
  );

  // Reference timing from n = rising edges since reset release.
  function automatic int hpos(input int n, input int dv, input int ht);
    return (n / dv) % ht;
  endfunction

  function automatic int vpos(input int n, input int dv, input int ht, input int vt);
    return (n / dv / ht) % vt;
  endfunction

  function automatic bit is_tick(input int n, input int dv);
    return ((n + 1) % dv) == 0;
  endfunction

  function automatic bit a_act(input int n);
    return (hpos(n, 4, 800) < 640) && (vpos(n, 4, 800, 525) < 480);
  endfunction

  function automatic logic [11:0] a_exp(input int n);
    logic [9:0] hh;
    logic [9:0] vv;
    hh = 10'(hpos(n, 4, 800));
    vv = 10'(vpos(n, 4, 800, 525));
    return a_act(n) ? {hh[3:0], vv[3:0], hh[7:4]} : 12'h000;
  endfunction

  function automatic bit c_act(input int n);
    return (hpos(n, 2, 24) < 16) && (vpos(n, 2, 24, 19) < 12);
  endfunction

  logic [11:0] exp_a_q[$];
  logic [11:0] exp_c_q[$];

  always @(negedge clk) begin
    if (!reset_a) begin
      exp_a_q.delete();
    end else if (is_tick(cyc - rel_ab, 4)) begin
      check("a_pix_x", a_x, hpos(cyc - rel_ab, 4, 800));
      check("a_pix_y", a_y, vpos(cyc - rel_ab, 4, 800, 525));
      check("a_pix_req", a_req, a_act(cyc - rel_ab));
      exp_a_q.push_back(a_exp(cyc - rel_ab));
      if (exp_a_q.size() > 2) check("a_rgb", {a_r, a_g, a_b}, exp_a_q.pop_front());
    end else begin
      check("a_pix_req_idle", a_req, 0);
    end
  end

  always @(negedge clk) begin
    if (!reset_c) begin
      exp_c_q.delete();
    end else if (is_tick(cyc - rel_c, 2)) begin
      check("c_pix_req", c_req, c_act(cyc - rel_c));
      exp_c_q.push_back(c_act(cyc - rel_c) ? 12'hFFF : 12'h000);
      if (exp_c_q.size() > 2) check("c_rgb", {c_r, c_g, c_b}, exp_c_q.pop_front());
    end
  end

  // Per-frame window totals for C, closed on each frame_start cycle.
  int c_vlo = 0, c_fff = 0, c_vlo_win = -1, c_fff_win = -1;
  int a_bad = 0, c_bad = 0;

  always @(negedge clk) begin
    if (!reset_c) begin
      c_vlo <= 0;
      c_fff <= 0;
    end else if (c_fs) begin
      c_vlo_win <= c_vlo + int'(!c_vs);
      c_fff_win <= c_fff + int'(is_tick(cyc - rel_c, 2) && ({c_r, c_g, c_b} == 12'hFFF));
      c_vlo     <= 0;
      c_fff     <= 0;
    end else begin
      c_vlo <= c_vlo + int'(!c_vs);
      c_fff <= c_fff + int'(is_tick(cyc - rel_c, 2) && ({c_r, c_g, c_b} == 12'hFFF));
    end
  end

  always @(negedge clk) begin
    if (reset_a && ({a_r, a_g, a_b} != 12'h0) && (!a_hs || !a_vs)) a_bad <= a_bad + 1;
    if (reset_c && ({c_r, c_g, c_b} != 12'h0) && (!c_hs || !c_vs)) c_bad <= c_bad + 1;
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return a_hs;
      1:       return b_hs;
      2:       return c_vs;
      3:       return c_fs;
      default: return a_req;
    endcase
  endfunction

  // Returns the rising-edge index (relative to base) after which sig(w) first reads lvl, or -1.
  task automatic wait_level(input int w, input logic lvl, input int base, output int at);
    at = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (sig(w) == lvl) begin
        at = cyc - base;
        break;
      end
    end
  endtask

  task automatic line_check(input string nm, input int w, input int first_exp,
                            input int period, input int low);
    int f1, r1, f2, r2, f3;
    wait_level(w, 1'b0, rel_ab, f1);
    check({nm, "_first_fall"}, f1, first_exp);
    wait_level(w, 1'b1, rel_ab, r1);
    check({nm, "_low_width"}, r1 - f1, low);
    wait_level(w, 1'b0, rel_ab, f2);
    check({nm, "_period"}, f2 - f1, period);
    wait_level(w, 1'b1, rel_ab, r2);
    check({nm, "_low_width2"}, r2 - f2, low);
    wait_level(w, 1'b0, rel_ab, f3);
    check({nm, "_period2"}, f3 - f2, period);
  endtask

  task automatic c_frame();
    int p1, p2, p3, q, k;
    wait_level(3, 1'b1, rel_ab, p1);
    check("c_first_frame_edge", p1 + 1, 912);
    @(negedge clk);
    check("c_wrap_x", c_x, 0);
    check("c_wrap_y", c_y, 0);
    wait_level(3, 1'b1, rel_ab, p2);
    check("c_frame_period", p2 - p1, 912);
    @(negedge clk);
    check("c_wrap_x2", c_x, 0);
    check("c_wrap_y2", c_y, 0);
    check("c_vsync_low_clk", c_vlo_win, 96);
    check("c_fff_ticks", c_fff_win, 192);
    wait_level(3, 1'b1, rel_ab, p3);
    check("c_frame_period2", p3 - p2, 912);
    @(negedge clk);
    check("c_vsync_low_clk2", c_vlo_win, 96);
    check("c_fff_ticks2", c_fff_win, 192);

    k = 0;
    while (k < 2000 && !(c_x == 10'd10 && c_y == 10'd7)) begin
      @(negedge clk);
      k++;
    end
    check("c_reach_mid_frame", int'(k < 2000), 1);
    @(posedge clk);
    #2 reset_c = 1'b0;
    #1;
    check("mid_rst_pix_x", c_x, 0);
    check("mid_rst_pix_y", c_y, 0);
    check("mid_rst_rgb", {c_r, c_g, c_b}, 0);
    check("mid_rst_hsync", c_hs, 1);
    check("mid_rst_vsync", c_vs, 1);
    check("mid_rst_pix_req", c_req, 0);
    check("mid_rst_frame_start", c_fs, 0);
    repeat (3) @(negedge clk);
    rel_c = cyc;
    reset_c = 1'b1;
    @(negedge clk);
    check("restart_x_edge1", c_x, 0);
    @(negedge clk);
    check("restart_x_edge2", c_x, 1);
    check("restart_y_edge2", c_y, 0);
    wait_level(3, 1'b1, rel_c, q);
    check("restart_frame_edge", q + 1, 912);
  endtask

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;
    reset_c = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_rgb", {a_r, a_g, a_b}, 0);
    check("rst_hsync", a_hs, 1);
    check("rst_vsync", a_vs, 1);
    check("rst_pix_req", a_req, 0);
    check("rst_pix_x", a_x, 0);
    check("rst_pix_y", a_y, 0);
    check("rst_frame_start", a_fs, 0);
    check("rst_div1_pix_req", b_req, 0);
    check("rst_div1_frame_start", b_fs, 0);
    check("rst_c_hsync", c_hs, 1);

    rel_ab = cyc;
    rel_c  = cyc;
    reset_a = 1'b1;
    reset_b = 1'b1;
    reset_c = 1'b1;

    fork
      begin : first_req
        int q;
        wait_level(4, 1'b1, rel_ab, q);
        // The strobe is seen in the cycle before the edge that consumes it.
        check("a_first_req_edge", q + 1, 4);
      end
      line_check("a_hsync", 0, 2633, 3200, 384);
      line_check("b_hsync", 1, 659, 800, 96);
      c_frame();
    join

    check("a_rgb_during_sync", a_bad, 0);
    check("c_rgb_during_sync", c_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
